// File: rtl/mem_stage_pipelined.sv
// mem_stage_pipelined: pipelined MEM stage with an internal data memory.
//   Resolves beq/bne (pc_src), performs byte/half/word loads and stores with
//   MEM_LATENCY cycles per access, stalls upstream while an access is in
//   flight, and registers results into the MEM/WB pipeline register.
//
// Ports:
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   in_valid ..           EX/MEM payload (address/result, store data, flags,
//   mem_to_reg_in         access size, destination and write-back controls)
//   stall                 hold upstream stages and keep inputs stable
//   pc_src                branch taken (combinational)
//   wb_*                  registered MEM/WB outputs
//   perf_loads/stores     completed load/store counters, present only when
//                         MEM_STAGE_PERF_COUNT_EN is defined
//
// Optional feature macro: MEM_STAGE_PERF_COUNT_EN
module mem_stage_pipelined #(
  parameter int unsigned ADDR_BITS   = 10,
  parameter int unsigned MEM_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [31:0] alu_result,
  input  logic [31:0] write_data,
  input  logic        alu_zero,
  input  logic        branch,
  input  logic        branch_ne,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  size,
  input  logic        load_unsigned,
  input  logic [4:0]  rd_in,
  input  logic        reg_write_in,
  input  logic        mem_to_reg_in,
  output logic        stall,
  output logic        pc_src,
  output logic        wb_valid,
  output logic        wb_reg_write,
  output logic        wb_mem_to_reg,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_read_data,
  output logic [31:0] wb_alu_result,
  output logic        wb_misalign
`ifdef MEM_STAGE_PERF_COUNT_EN
  ,
  output logic [31:0] perf_loads,
  output logic [31:0] perf_stores
`endif
);

  localparam int unsigned DEPTH = 2 ** ADDR_BITS;
  localparam int unsigned CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  // Address decode: word index wraps, lane picks the byte inside the word.
  logic [ADDR_BITS-1:0] word_idx_c;
  logic [1:0]           lane_c;
  assign word_idx_c = alu_result[ADDR_BITS+1:2];
  assign lane_c     = alu_result[1:0];

  // Branch resolution, independent of the memory pipeline.
  assign pc_src = in_valid & branch & (alu_zero ^ branch_ne);

  // Access classification.
  logic misaligned_c;
  logic mem_op_c;
  logic mis_op_c;
  logic access_c;
  logic store_c;
  logic load_c;

  always_comb begin
    misaligned_c = 1'b0;
    case (size)
      2'b00:   misaligned_c = 1'b0;
      2'b01:   misaligned_c = lane_c[0];
      default: misaligned_c = |lane_c;
    endcase
  end

  assign mem_op_c = in_valid & (mem_read | mem_write);
  assign mis_op_c = mem_op_c & misaligned_c;
  assign access_c = mem_op_c & ~misaligned_c;
  // A simultaneous read/write request is treated as a store only.
  assign store_c  = access_c & mem_write;
  assign load_c   = access_c & mem_read & ~mem_write;

  // Latency FSM: counts down the extra cycles of a multi-cycle access.
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stall_c;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (access_c && (MEM_LATENCY > 1)) begin
          stall_c = 1'b1;
          cnt_d   = CNT_W'(MEM_LATENCY - 1);
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q == CNT_W'(1)) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          stall_c = 1'b1;
          cnt_d   = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // Upstream sees no stall while reset is held, even if a request is pending.
  assign stall = stall_c & ~reset;

  // Store lane steering: replicate data and enable only the addressed lanes.
  logic [3:0]  be_c;
  logic [31:0] wdata_c;
  logic        mem_we_c;

  always_comb begin
    be_c    = 4'b0000;
    wdata_c = write_data;
    case (size)
      2'b00: begin
        be_c    = 4'b0001 << lane_c;
        wdata_c = {4{write_data[7:0]}};
      end
      2'b01: begin
        be_c    = lane_c[1] ? 4'b1100 : 4'b0011;
        wdata_c = {2{write_data[15:0]}};
      end
      default: begin
        be_c    = 4'b1111;
        wdata_c = write_data;
      end
    endcase
  end

  // Writes happen only on the completion edge; an aborted access never gets there.
  assign mem_we_c = store_c & ~stall_c;

  // Data memory, intentionally not reset.
  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (mem_we_c) begin
      for (int i = 0; i < 4; i++) begin
        if (be_c[i]) begin
          mem[word_idx_c][8*i +: 8] <= wdata_c[8*i +: 8];
        end
      end
    end
  end

  // Load path: combinational word read, lane extract, sign/zero extension.
  logic [31:0] rd_word_c;
  logic [7:0]  byte_c;
  logic [15:0] half_c;
  logic [31:0] load_data_c;

  assign rd_word_c = mem[word_idx_c];

  always_comb begin
    byte_c = rd_word_c[7:0];
    case (lane_c)
      2'd0:    byte_c = rd_word_c[7:0];
      2'd1:    byte_c = rd_word_c[15:8];
      2'd2:    byte_c = rd_word_c[23:16];
      default: byte_c = rd_word_c[31:24];
    endcase
    half_c      = lane_c[1] ? rd_word_c[31:16] : rd_word_c[15:0];
    load_data_c = rd_word_c;
    case (size)
      2'b00:   load_data_c = load_unsigned ? {24'h0, byte_c} : {{24{byte_c[7]}}, byte_c};
      2'b01:   load_data_c = load_unsigned ? {16'h0, half_c} : {{16{half_c[15]}}, half_c};
      default: load_data_c = rd_word_c;
    endcase
  end

  // MEM/WB pipeline register: advances on every non-stalled edge.
  logic        wb_valid_q, wb_valid_d;
  logic        wb_reg_write_q, wb_reg_write_d;
  logic        wb_mem_to_reg_q, wb_mem_to_reg_d;
  logic [4:0]  wb_rd_q, wb_rd_d;
  logic [31:0] wb_read_data_q, wb_read_data_d;
  logic [31:0] wb_alu_result_q, wb_alu_result_d;
  logic        wb_misalign_q, wb_misalign_d;

  always_comb begin
    wb_valid_d      = wb_valid_q;
    wb_reg_write_d  = wb_reg_write_q;
    wb_mem_to_reg_d = wb_mem_to_reg_q;
    wb_rd_d         = wb_rd_q;
    wb_read_data_d  = wb_read_data_q;
    wb_alu_result_d = wb_alu_result_q;
    wb_misalign_d   = wb_misalign_q;
    if (!stall_c) begin
      wb_valid_d      = in_valid;
      wb_reg_write_d  = in_valid & reg_write_in & ~mis_op_c;
      wb_mem_to_reg_d = mem_to_reg_in;
      wb_rd_d         = rd_in;
      wb_read_data_d  = load_c ? load_data_c : 32'h0;
      wb_alu_result_d = alu_result;
      wb_misalign_d   = mis_op_c;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wb_valid_q      <= 1'b0;
      wb_reg_write_q  <= 1'b0;
      wb_mem_to_reg_q <= 1'b0;
      wb_rd_q         <= 5'h0;
      wb_read_data_q  <= 32'h0;
      wb_alu_result_q <= 32'h0;
      wb_misalign_q   <= 1'b0;
    end else begin
      wb_valid_q      <= wb_valid_d;
      wb_reg_write_q  <= wb_reg_write_d;
      wb_mem_to_reg_q <= wb_mem_to_reg_d;
      wb_rd_q         <= wb_rd_d;
      wb_read_data_q  <= wb_read_data_d;
      wb_alu_result_q <= wb_alu_result_d;
      wb_misalign_q   <= wb_misalign_d;
    end
  end

  assign wb_valid      = wb_valid_q;
  assign wb_reg_write  = wb_reg_write_q;
  assign wb_mem_to_reg = wb_mem_to_reg_q;
  assign wb_rd         = wb_rd_q;
  assign wb_read_data  = wb_read_data_q;
  assign wb_alu_result = wb_alu_result_q;
  assign wb_misalign   = wb_misalign_q;

`ifdef MEM_STAGE_PERF_COUNT_EN
  // Completed aligned load/store counters, free-running with wrap.
  logic [31:0] perf_loads_q, perf_loads_d;
  logic [31:0] perf_stores_q, perf_stores_d;

  always_comb begin
    perf_loads_d  = perf_loads_q;
    perf_stores_d = perf_stores_q;
    if (!stall_c && load_c) begin
      perf_loads_d = perf_loads_q + 32'd1;
    end
    if (!stall_c && store_c) begin
      perf_stores_d = perf_stores_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_loads_q  <= 32'h0;
      perf_stores_q <= 32'h0;
    end else begin
      perf_loads_q  <= perf_loads_d;
      perf_stores_q <= perf_stores_d;
    end
  end

  assign perf_loads  = perf_loads_q;
  assign perf_stores = perf_stores_q;
`endif

endmodule

// File: doc/mem_stage_pipelined.md
Name: mem_stage_pipelined

Overview:
- Parametrised successor of the combinational MEM stage.
- Resolves branch PCSrc (beq/bne), performs byte/half/word loads and stores to an internal data memory with configurable multi-cycle latency, and registers results into the MEM/WB pipeline register.
- Drives a stall back to the IF/ID/EX stages while a memory access is in flight.
- Sits between the EX/MEM register and the write-back stage.

Parameters:
- ADDR_BITS, 10: word-address width; memory holds 2**ADDR_BITS 32-bit words. Byte address bits [ADDR_BITS+1:2] select the word; higher bits are ignored, so addresses wrap.
- MEM_LATENCY, 1: total cycles per load/store, must be >= 1. MEM_LATENCY-1 of those cycles are stall cycles.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  EX/MEM slot holds a real instruction
- alu_result  in  32  byte address for loads/stores, or pass-through result
- write_data  in  32  store data (rt)
- alu_zero  in  1  ALU zero flag
- branch  in  1  branch instruction
- branch_ne  in  1  1 = bne, 0 = beq
- mem_read  in  1  load
- mem_write  in  1  store
- size  in  2  00 byte, 01 half, 10 word, 11 treated as word
- load_unsigned  in  1  zero-extend sub-word loads (lbu/lhu)
- rd_in  in  5  destination register
- reg_write_in  in  1  write-back enable
- mem_to_reg_in  in  1  write-back source select
- stall  out  1  hold upstream stages and inputs stable
- pc_src  out  1  take branch
- wb_valid, wb_reg_write, wb_mem_to_reg  out  1 each  registered controls
- wb_rd  out  5  registered destination register
- wb_read_data, wb_alu_result  out  32 each  registered data
- wb_misalign  out  1  registered misalignment flag

Behaviour:
- pc_src = in_valid & branch & (alu_zero ^ branch_ne). Combinational, not gated by stall.
- access = in_valid & (mem_read | mem_write) & ~misaligned.
  - Misaligned: a half access with addr[0]=1, or a word access with addr[1:0]!=0.
  - If mem_read and mem_write are both set, the store wins and no load data is returned.
- FSM states IDLE and BUSY, with down-counter cnt.
  - IDLE, access, MEM_LATENCY==1: completion cycle, stall=0.
  - IDLE, access, MEM_LATENCY>1: stall=1, cnt<=MEM_LATENCY-1, go to BUSY.
  - BUSY, cnt==1: completion cycle, stall=0, go to IDLE.
  - BUSY, cnt>1: stall=1, cnt<=cnt-1.
  - Result: exactly MEM_LATENCY-1 stall cycles, then completion.
- Inputs must stay stable while stall=1; the block samples them only in the completion cycle.
- Store, at the completion clock edge, into lane addr[1:0]:
  - byte: write_data[7:0]
  - half: write_data[15:0] into lanes {addr[1],0}
  - word: full word
  - Other lanes are unchanged.
- Load: the word is read combinationally in the completion cycle, then the lane is extracted and sign- or zero-extended per load_unsigned.
- MEM/WB register updates on every edge where stall=0:
  - wb_valid<=in_valid
  - wb_reg_write<=in_valid & reg_write_in & ~misaligned_mem_op
  - other wb_* fields follow their inputs; wb_misalign<=in_valid & (mem_read|mem_write) & misaligned
- While stall=1 the MEM/WB register holds its value. Downstream sees one result per instruction.
- Misaligned access: no memory write, no stall, and the flag is registered.
- Bubble (in_valid=0): wb_valid=0, wb_reg_write=0, no memory activity.
- Reset, asynchronous: state IDLE, cnt=0, stall=0, all wb_* = 0.
  - Memory array is not reset.
  - A store in flight when reset asserts is aborted and does not write.

Optional Feature:
- Macro MEM_STAGE_PERF_COUNT_EN.
- Defined: adds output ports perf_loads[31:0] and perf_stores[31:0].
  - Each increments on the completion cycle of a non-misaligned load or store respectively.
  - Counters wrap at 2**32 and reset to 0.
- Undefined: ports and logic absent; behaviour otherwise identical.

Test Plan:
- MEM_LATENCY=1: sw 0xDEADBEEF @0x10, then lw @0x10 -> wb_read_data=0xDEADBEEF one cycle later, stall never asserted.
- MEM_LATENCY=3: lw -> stall high exactly 2 cycles; wb_valid and data appear on the 3rd edge; wb_* held during stall.
- Sub-word: word 0x80FF7F01 @0x20; lb @0x23 -> 0xFFFFFF80; lbu @0x23 -> 0x00000080; lh @0x22 -> 0xFFFF80FF; sb 0xAA @0x21 -> word reads 0x80FFAA01.
- Misaligned: lw @0x22, reg_write_in=1 -> wb_misalign=1, wb_reg_write=0, no stall, memory unchanged.
- Branch: branch=1, alu_zero=1, branch_ne=0 -> pc_src=1; with branch_ne=1 -> pc_src=0; in_valid=0 -> pc_src=0.
- MEM_LATENCY=4: reset asserted during the 2nd stall cycle of sw -> stall=0 and wb_*=0 immediately; target word unchanged after reset.
